decoder_scan_nbits: RTL
=======================

# decoder_scan_nbits

Registered, parametrised N-to-2^N one-hot decoder with three modes. Direct mode is a handshaked, registered decode. Continuous-scan mode and single-sweep mode use an internal index counter and a programmable dwell. This block is the sequential successor to the combinational hierarchical decoder. It drives row/digit-select and channel-strobe lines that must be glitch-free, held for a fixed number of cycles, or swept autonomously.

## Interface
Parameters:
- N, 4, address width; legal 2..8; o_Y width is 2^N.
- DWELL_W, 8, width of the dwell field.

Ports:
- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST_n  in  1  reset; asynchronous, active-low; release is synchronised by the integrating level.
- i_EN  in  1  global enable; 0 blanks o_Y and aborts any activity.
- i_MODE  in  2  mode select:
  - 00: direct
  - 01: continuous scan
  - 10: single sweep
  - 11: reserved, behaves as 00
- i_A  in  N  direct-mode address.
- i_VALID  in  1  direct-mode load strobe; no back-pressure, the block always accepts.
- i_DWELL  in  DWELL_W  hold count per position, minus 1 (D).
- i_START  in  1  single-sweep trigger.
- o_Y  out  2^N  registered one-hot output, or all-zero.
- o_IDX  out  N  registered index currently decoded.
- o_BUSY  out  1  single sweep in progress.
- o_DONE  out  1  one-cycle pulse at sweep completion.
- o_WRAP  out  1  one-cycle pulse when the continuous scan wraps to index 0.

## Operation
- Reset values: o_Y=0, o_IDX=0, o_BUSY=0, o_DONE=0, o_WRAP=0, dwell counter=0, state=IDLE.
- States:
  - IDLE: o_Y=0.
  - HOLD: direct mode, one line active.
  - SCAN.
  - SWEEP.
  - Invariant: o_Y is all-zero or exactly one-hot, and o_Y = (1 << o_IDX) whenever it is non-zero.
- Mode-change rule: the previous i_MODE is registered. Any change, or i_EN=0, forces IDLE on the next edge:
  - o_Y=0, o_BUSY=0, dwell counter cleared.
  - No o_DONE or o_WRAP is generated.
  - o_IDX holds its value.
- Direct mode (00/11):
  - i_EN=1 and i_VALID=1 → HOLD; o_IDX=i_A and o_Y=one-hot(i_A) on the next edge.
  - HOLD is retained until the next valid or an abort.
  - i_VALID with i_EN=0 is ignored.
  - After an abort, o_Y stays 0 until a new i_VALID.
- Continuous scan (01), entered from IDLE when i_EN=1 and mode=01:
  - Next edge: o_IDX=0, o_Y=one-hot(0), dwell counter=0.
  - The dwell counter increments every cycle. When it equals D, the next edge advances o_IDX by 1 modulo 2^N and clears the counter.
  - i_DWELL is sampled only when the counter is 0 (position start). A mid-dwell change takes effect at the next position.
  - On the advance 2^N-1 → 0, o_WRAP=1 for exactly the cycle in which o_IDX first shows 0. It does not fire on scan entry.
  - D=0: advance every cycle.
- Single sweep (10):
  - IDLE with i_EN=1 and i_START=1 → SWEEP; next edge o_BUSY=1, o_IDX=0, o_Y=one-hot(0).
  - Advance as in scan, with D sampled the same way.
  - After position 2^N-1 has been held D+1 cycles, the next edge gives o_Y=0, o_BUSY=0, o_DONE=1 for one cycle, and returns to IDLE. o_IDX holds 2^N-1.
  - i_START while BUSY is ignored.
  - i_START in the o_DONE cycle starts a new sweep on the following edge.
- Dwell arithmetic: the counter is DWELL_W bits, compared with equality, and never wraps. Maximum hold is 2^DWELL_W cycles per position.

## Timing
- All outputs are registered, with no combinational path from any input to any output.
- Direct decode latency: 1 cycle from i_VALID.
- Scan/sweep start latency: 1 cycle from mode entry or i_START.
- Each position is visible for exactly D+1 cycles. Consecutive positions are back-to-back, with no zero cycle between them.
- Sweep: o_BUSY is high for exactly 2^N·(D+1) cycles; o_DONE is asserted on the first cycle after o_BUSY falls.
- Abort latency: 1 cycle to o_Y=0.
- Asynchronous reset clears all outputs immediately, mid-operation included.

## Test plan
- N=4, mode 00, i_VALID pulses with i_A=5, then i_A=15 → o_Y=0x0020 one cycle after the first, 0x8000 one cycle after the second; o_Y held between pulses.
- N=4, mode 01, D=2 → each index held for 3 cycles, sequence 0..15; o_WRAP=1 exactly once per 48 cycles, coincident with o_IDX=0.
- N=3, mode 10, D=0, i_START → o_BUSY high for 8 cycles with o_Y=0x01..0x80; then o_DONE=1 for 1 cycle with o_Y=0; a second i_START during BUSY is ignored.
- Sweep in progress at o_IDX=6, then i_EN=0 → next cycle o_Y=0, o_BUSY=0, and o_DONE never asserts.
- Mode 01 running, i_MODE switched to 00 mid-dwell → one cycle o_Y=0 and no o_WRAP; the next i_VALID with i_A=3 gives o_Y=0x0008.
- Assert i_RST_n=0 asynchronously mid-scan → all outputs are 0 immediately without a clock edge; after release with mode 01, the scan restarts at index 0.

Source files
------------

// File: rtl/decoder_scan_nbits_if.sv
// decoder_scan_nbits_if
// Bundles the control and result signals of decoder_scan_nbits.
//   i_EN     global enable; low blanks the outputs and aborts activity
//   i_MODE   00 direct, 01 continuous scan, 10 single sweep, 11 as direct
//   i_A      direct-mode address
//   i_VALID  direct-mode load strobe (always accepted)
//   i_DWELL  hold count per position minus one
//   i_START  single-sweep trigger
//   o_Y      registered one-hot select lines, or all zero
//   o_IDX    registered index currently decoded
//   o_BUSY   single sweep in progress
//   o_DONE   one-cycle pulse when a sweep completes
//   o_WRAP   one-cycle pulse when the continuous scan wraps to index 0
// master: the side that drives the controls; slave: the decoder itself.
interface decoder_scan_nbits_if #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
) ();

  logic               i_EN;
  logic [1:0]         i_MODE;
  logic [N-1:0]       i_A;
  logic               i_VALID;
  logic [DWELL_W-1:0] i_DWELL;
  logic               i_START;
  logic [(1<<N)-1:0]  o_Y;
  logic [N-1:0]       o_IDX;
  logic               o_BUSY;
  logic               o_DONE;
  logic               o_WRAP;

  modport master (
    output i_EN, i_MODE, i_A, i_VALID, i_DWELL, i_START,
    input  o_Y, o_IDX, o_BUSY, o_DONE, o_WRAP
  );

  modport slave (
    input  i_EN, i_MODE, i_A, i_VALID, i_DWELL, i_START,
    output o_Y, o_IDX, o_BUSY, o_DONE, o_WRAP
  );

endinterface

// File: rtl/decoder_scan_nbits.sv
// decoder_scan_nbits
// Registered N-to-2^N one-hot decoder with three modes:
//   direct         : i_VALID loads i_A, the matching line is held until the
//                    next load or an abort
//   continuous scan: lines are stepped 0..2^N-1 forever, each held D+1 cycles
//   single sweep   : one pass 0..2^N-1 on i_START, then o_DONE
// Ports:
//   i_CLK    clock, rising edge
//   i_RST_n  asynchronous active-low reset
//   bus      decoder_scan_nbits_if slave modport (controls in, results out)
// Every output comes straight from a flop, so the select lines never glitch.
module decoder_scan_nbits #(
  parameter int N       = 4,
  parameter int DWELL_W = 8
) (
  input  logic                 i_CLK,
  input  logic                 i_RST_n,
  decoder_scan_nbits_if.slave  bus
);

  localparam int           NUM_LINES = 1 << N;
  localparam logic [N-1:0] LAST_IDX  = {N{1'b1}};

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_SCAN,
    ST_SWEEP
  } state_e;

  state_e                 state_q,    state_d;
  logic [1:0]             prevMode_q, prevMode_d;
  logic [N-1:0]           idx_q,      idx_d;
  logic [NUM_LINES-1:0]   y_q,        y_d;
  logic                   busy_q,     busy_d;
  logic                   done_q,     done_d;
  logic                   wrap_q,     wrap_d;
  logic [DWELL_W-1:0]     cnt_q,      cnt_d;
  logic [DWELL_W-1:0]     dwell_q,    dwell_d;

  logic [1:0]             modeNorm;
  logic                   abort;
  logic [DWELL_W-1:0]     activeDwell;
  logic                   posEnd;
  logic [N-1:0]           idxNext;

  function automatic logic [NUM_LINES-1:0] oneHot(input logic [N-1:0] sel);
    logic [NUM_LINES-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

  // The reserved mode is folded onto direct so that 00 <-> 11 is not seen as
  // a mode change.
  assign modeNorm = (bus.i_MODE == 2'b11) ? MODE_DIRECT : bus.i_MODE;

  // Only an active state can be aborted; from IDLE a new mode is dispatched
  // straight away so that scan entry takes a single cycle.
  assign abort = (state_q != ST_IDLE) && (!bus.i_EN || (modeNorm != prevMode_q));

  // The dwell is latched in the first cycle of each position, so a change to
  // i_DWELL part-way through a position only affects the following one.
  assign activeDwell = (cnt_q == '0) ? bus.i_DWELL : dwell_q;
  assign posEnd      = (cnt_q == activeDwell);
  assign idxNext     = idx_q + N'(1);

  // Next-state and output logic. All outputs are computed here and
  // registered, so nothing on the interface is combinational from an input.
  always_comb begin
    state_d    = state_q;
    prevMode_d = modeNorm;
    idx_d      = idx_q;
    y_d        = y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    wrap_d     = 1'b0;
    cnt_d      = cnt_q;
    dwell_d    = dwell_q;

    if (abort) begin
      state_d = ST_IDLE;
      y_d     = '0;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          y_d    = '0;
          busy_d = 1'b0;
          cnt_d  = '0;
          if (bus.i_EN) begin
            case (modeNorm)
              MODE_SCAN: begin
                state_d = ST_SCAN;
                idx_d   = '0;
                y_d     = oneHot('0);
              end
              MODE_SWEEP: begin
                if (bus.i_START) begin
                  state_d = ST_SWEEP;
                  idx_d   = '0;
                  y_d     = oneHot('0);
                  busy_d  = 1'b1;
                end
              end
              default: begin
                if (bus.i_VALID) begin
                  state_d = ST_HOLD;
                  idx_d   = bus.i_A;
                  y_d     = oneHot(bus.i_A);
                end
              end
            endcase
          end
        end

        ST_HOLD: begin
          if (bus.i_VALID) begin
            idx_d = bus.i_A;
            y_d   = oneHot(bus.i_A);
          end
        end

        ST_SCAN, ST_SWEEP: begin
          if (cnt_q == '0) begin
            dwell_d = bus.i_DWELL;
          end
          if (posEnd) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              if (state_q == ST_SWEEP) begin
                // Sweep finished: blank, drop busy, pulse done, keep the
                // last index visible on o_IDX.
                state_d = ST_IDLE;
                y_d     = '0;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end else begin
                idx_d  = '0;
                y_d    = oneHot('0);
                wrap_d = 1'b1;
              end
            end else begin
              idx_d = idxNext;
              y_d   = oneHot(idxNext);
            end
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end

        default: begin
          state_d = ST_IDLE;
          y_d     = '0;
          busy_d  = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and output registers; reset clears everything at once, without
  // waiting for a clock edge.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q    <= ST_IDLE;
      prevMode_q <= MODE_DIRECT;
      idx_q      <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      cnt_q      <= '0;
      dwell_q    <= '0;
    end else begin
      state_q    <= state_d;
      prevMode_q <= prevMode_d;
      idx_q      <= idx_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      cnt_q      <= cnt_d;
      dwell_q    <= dwell_d;
    end
  end

  assign bus.o_Y    = y_q;
  assign bus.o_IDX  = idx_q;
  assign bus.o_BUSY = busy_q;
  assign bus.o_DONE = done_q;
  assign bus.o_WRAP = wrap_q;

endmodule
